// File: rtl/dram_init_responder_pkg.sv
// Shared types and constants for the DDR4 init responder.
// Holds the responder state encoding, decoded command and error types,
// default JEDEC-style timing values and the mode-register load order.
package dram_init_responder_pkg;

  // Default timing in controller clock cycles. Benches override these
  // through the top-level parameters.
  localparam int tXPR     = 24;
  localparam int tMOD     = 24;
  localparam int tZQinitc = 1024;

  // Responder state. This is a plain logic vector with named constants so
  // that older code comparing against raw encodings keeps working.
  typedef logic [2:0] dram_dev_state_t;
  localparam dram_dev_state_t D_RESET    = 3'd0;
  localparam dram_dev_state_t D_CKE_WAIT = 3'd1;
  localparam dram_dev_state_t D_XPR      = 3'd2;
  localparam dram_dev_state_t D_MRS      = 3'd3;
  localparam dram_dev_state_t D_ZQ       = 3'd4;
  localparam dram_dev_state_t D_READY    = 3'd5;
  localparam dram_dev_state_t D_ERROR    = 3'd6;

  typedef enum logic [2:0] {
    C_DES,
    C_NOP,
    C_MRS,
    C_ZQ,
    C_ILLEGAL
  } dram_cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_TIMING,
    ERR_ORDER,
    ERR_ILLEGAL,
    ERR_CKE
  } dram_err_t;

  // Mode registers must be written MR3,MR6,MR5,MR4,MR2,MR1,MR0. Entry 7 is a
  // sentinel: MR index 7 always decodes as illegal, so once all seven are
  // loaded any further MRS fails the order comparison.
  localparam logic [2:0] MRS_ORDER [8] = '{
    3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0, 3'd7
  };

endpackage

// File: rtl/dram_init_responder_if.sv
// Controller-to-DRAM command pin bundle.
// master: controller side, drives every pin.
// slave : device side (responder), samples every pin.
// Pins: mem_reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n, bg[1:0], ba[1:0], a10.
interface dram_init_responder_if;
  logic       mem_reset_n;
  logic       cke;
  logic       cs_n;
  logic       act_n;
  logic       ras_n;
  logic       cas_n;
  logic       we_n;
  logic [1:0] bg;
  logic [1:0] ba;
  logic       a10;

  modport master (
    output mem_reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a10
  );

  modport slave (
    input mem_reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a10
  );
endinterface

// File: rtl/dram_init_responder_cmd_decode.sv
// Combinational DDR4 command decoder for the init responder.
// Inputs : cs_n, act_n, ras_n, cas_n, we_n, bg[1:0], ba[1:0]
// Outputs: cmd_type (DES/NOP/MRS/ZQ/ILLEGAL), mr_idx = {bg[0], ba}
module dram_init_responder_cmd_decode
  import dram_init_responder_pkg::*;
(
  input  logic       cs_n,
  input  logic       act_n,
  input  logic       ras_n,
  input  logic       cas_n,
  input  logic       we_n,
  input  logic [1:0] bg,
  input  logic [1:0] ba,
  output dram_cmd_t  cmd_type,
  output logic [2:0] mr_idx
);

  // Only bg[0] takes part in the MR index; bg[1] is a don't-care here.
  logic unused_bg1;
  assign unused_bg1 = bg[1];

  assign mr_idx = {bg[0], ba};

  // Deselect dominates; with chip select active, act_n low is an ACTIVATE,
  // which has no place in the init sequence and is treated as illegal.
  always_comb begin
    cmd_type = C_ILLEGAL;
    if (cs_n) begin
      cmd_type = C_DES;
    end else if (act_n) begin
      case ({ras_n, cas_n, we_n})
        3'b111:  cmd_type = C_NOP;
        3'b000:  cmd_type = (mr_idx == 3'd7) ? C_ILLEGAL : C_MRS;
        3'b110:  cmd_type = C_ZQ;
        default: cmd_type = C_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/dram_init_responder.sv
// Device-side DDR4 power-up/initialisation responder and protocol checker.
// Tracks the init sequence (CKE rise, tXPR, seven MRS in fixed order with
// tMOD spacing, ZQCL, tZQinit) and reports ready or the first error seen.
// Ports:
//   CLK, nRST  : clock, asynchronous active-low reset
//   cmd        : command pin bundle (slave modport)
//   dev_state  : current responder state (direct register view)
//   mr_loaded  : bit i set once MRi has been accepted
//   ready      : init sequence complete
//   err        : sticky error flag
//   err_code   : cause of the first error, ERR_NONE while err is low
module dram_init_responder
  import dram_init_responder_pkg::*;
#(
  parameter int T_XPR    = tXPR,
  parameter int T_MOD    = tMOD,
  parameter int T_ZQINIT = tZQinitc,
  parameter int CNT_W    = 12
) (
  input  logic                  CLK,
  input  logic                  nRST,
  dram_init_responder_if.slave  cmd,
  output dram_dev_state_t       dev_state,
  output logic [6:0]            mr_loaded,
  output logic                  ready,
  output logic                  err,
  output dram_err_t             err_code
);

  // gcnt holds (cycles since reference event) - 1, so "at least T cycles
  // later" is gcnt >= T-1.
  localparam logic [CNT_W-1:0] XPR_MIN = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] MOD_MIN = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] ZQ_END  = CNT_W'(T_ZQINIT - 1);

  dram_dev_state_t  state, state_nxt;
  logic [CNT_W-1:0] gcnt;
  logic             gcnt_clr;
  logic [2:0]       ptr, ptr_nxt;
  logic [6:0]       mr_nxt;
  logic             err_hit;
  dram_err_t        err_sel;
  dram_cmd_t        cmd_type;
  logic [2:0]       mr_idx;
  logic             gap_ok;

  dram_init_responder_cmd_decode u_decode (
    .cs_n     (cmd.cs_n),
    .act_n    (cmd.act_n),
    .ras_n    (cmd.ras_n),
    .cas_n    (cmd.cas_n),
    .we_n     (cmd.we_n),
    .bg       (cmd.bg),
    .ba       (cmd.ba),
    .cmd_type (cmd_type),
    .mr_idx   (mr_idx)
  );

  assign dev_state = state;

  // The first MRS is measured from the CKE rise, later ones from the
  // previous MRS.
  assign gap_ok = (ptr == 3'd0) ? (gcnt >= XPR_MIN) : (gcnt >= MOD_MIN);

  // Next-state and check logic. A CKE drop is reported ahead of any command
  // fault seen in the same cycle; an error always diverts to D_ERROR.
  always_comb begin
    state_nxt = state;
    gcnt_clr  = 1'b0;
    ptr_nxt   = ptr;
    mr_nxt    = mr_loaded;
    err_hit   = 1'b0;
    err_sel   = ERR_NONE;

    case (state)
      D_RESET: begin
        state_nxt = D_CKE_WAIT;
      end

      D_CKE_WAIT: begin
        if (cmd.cke) begin
          state_nxt = D_XPR;
          gcnt_clr  = 1'b1;
        end
      end

      D_XPR, D_MRS: begin
        if (!cmd.cke) begin
          err_hit = 1'b1;
          err_sel = ERR_CKE;
        end else begin
          case (cmd_type)
            C_DES, C_NOP: begin
              if (state == D_XPR && gcnt >= XPR_MIN) state_nxt = D_MRS;
            end
            C_MRS: begin
              if (!gap_ok) begin
                err_hit = 1'b1;
                err_sel = ERR_TIMING;
              end else if (mr_idx != MRS_ORDER[ptr]) begin
                err_hit = 1'b1;
                err_sel = ERR_ORDER;
              end else begin
                mr_nxt    = mr_loaded | (7'd1 << mr_idx);
                ptr_nxt   = ptr + 3'd1;
                gcnt_clr  = 1'b1;
                state_nxt = D_MRS;
              end
            end
            C_ZQ: begin
              err_hit = 1'b1;
              if (state == D_XPR) begin
                err_sel = ERR_ILLEGAL;
              end else if (ptr != 3'd7) begin
                err_sel = ERR_ORDER;
              end else if (!cmd.a10) begin
                err_sel = ERR_ILLEGAL;
              end else if (gcnt < MOD_MIN) begin
                err_sel = ERR_TIMING;
              end else begin
                err_hit   = 1'b0;
                gcnt_clr  = 1'b1;
                state_nxt = D_ZQ;
              end
            end
            default: begin
              err_hit = 1'b1;
              err_sel = ERR_ILLEGAL;
            end
          endcase
        end
      end

      D_ZQ: begin
        if (!cmd.cke) begin
          err_hit = 1'b1;
          err_sel = ERR_CKE;
        end else if (cmd_type != C_DES && cmd_type != C_NOP) begin
          err_hit = 1'b1;
          err_sel = ERR_TIMING;
        end else if (gcnt == ZQ_END) begin
          state_nxt = D_READY;
        end
      end

      D_READY: state_nxt = D_READY;
      D_ERROR: state_nxt = D_ERROR;
      default: state_nxt = D_RESET;
    endcase

    if (err_hit) state_nxt = D_ERROR;
  end

  // State registers. The sampled DRAM RESET_n acts like a synchronous reset
  // and overrides whatever command arrives in the same cycle. Errors can only
  // be raised outside D_ERROR, so the first cause stays latched.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= D_RESET;
      gcnt      <= '0;
      ptr       <= 3'd0;
      mr_loaded <= 7'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (!cmd.mem_reset_n) begin
      state     <= D_RESET;
      gcnt      <= '0;
      ptr       <= 3'd0;
      mr_loaded <= 7'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      mr_loaded <= mr_nxt;
      if (gcnt_clr)   gcnt <= '0;
      else if (~&gcnt) gcnt <= gcnt + 1'b1;
      if (err_hit) begin
        err      <= 1'b1;
        err_code <= err_sel;
        ready    <= 1'b0;
      end else if (state_nxt == D_READY) begin
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_init_responder.sv
// Directed self-checking bench for dram_init_responder with
// T_XPR=8, T_MOD=4, T_ZQINIT=16. Cycle cN below means the Nth rising edge
// after CKE is sampled high (c0).
module tb_dram_init_responder;
  import dram_init_responder_pkg::*;

  logic            CLK = 1'b0;
  logic            nRST;
  dram_dev_state_t dev_state;
  logic [6:0]      mr_loaded;
  logic            ready;
  logic            err;
  dram_err_t       err_code;

  int checks = 0;
  int fails  = 0;
  int order [7] = '{3, 6, 5, 4, 2, 1, 0};

  dram_init_responder_if bus ();

  dram_init_responder #(
    .T_XPR    (8),
    .T_MOD    (4),
    .T_ZQINIT (16),
    .CNT_W    (12)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .cmd       (bus.slave),
    .dev_state (dev_state),
    .mr_loaded (mr_loaded),
    .ready     (ready),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    bus.cs_n = 1'b0; bus.act_n = 1'b1;
    bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1;
    bus.bg = 2'b00; bus.ba = 2'b00; bus.a10 = 1'b0;
  endtask

  task automatic set_mrs(input int idx);
    logic [2:0] i3;
    i3 = idx[2:0];
    bus.cs_n = 1'b0; bus.act_n = 1'b1;
    bus.ras_n = 1'b0; bus.cas_n = 1'b0; bus.we_n = 1'b0;
    bus.bg = {1'b0, i3[2]}; bus.ba = i3[1:0]; bus.a10 = 1'b0;
  endtask

  task automatic set_zq(input logic a);
    bus.cs_n = 1'b0; bus.act_n = 1'b1;
    bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b0;
    bus.bg = 2'b00; bus.ba = 2'b00; bus.a10 = a;
  endtask

  task automatic idle(input int n);
    set_nop();
    repeat (n) tick();
  endtask

  task automatic issue_mrs(input int idx);
    set_mrs(idx);
    tick();
    set_nop();
  endtask

  task automatic issue_zq(input logic a);
    set_zq(a);
    tick();
    set_nop();
  endtask

  // Full reset: both resets low, then nRST released with RESET_n still low.
  task automatic hold_reset();
    nRST = 1'b0; bus.mem_reset_n = 1'b0; bus.cke = 1'b0;
    bus.cs_n = 1'b1; bus.act_n = 1'b1;
    bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1;
    bus.bg = 2'b00; bus.ba = 2'b00; bus.a10 = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  // From D_RESET: release RESET_n with CKE low, then raise CKE (edge c0).
  task automatic bring_up();
    bus.mem_reset_n = 1'b1; bus.cke = 1'b0;
    set_nop();
    tick();
    bus.cke = 1'b1;
    tick();
  endtask

  // First MRS at c8, subsequent ones every 4 cycles.
  task automatic load_mrs(input int n);
    idle(7);
    issue_mrs(order[0]);
    for (int i = 1; i < n; i++) begin
      idle(3);
      issue_mrs(order[i]);
    end
  endtask

  initial begin
    // Reset state and RESET_n hold
    hold_reset();
    check("rst_state", 32'(dev_state), 32'(D_RESET));
    check("rst_mr", 32'(mr_loaded), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_code", 32'(err_code), 32'(ERR_NONE));

    bus.mem_reset_n = 1'b1;
    tick();
    check("cke_wait_state", 32'(dev_state), 32'(D_CKE_WAIT));
    issue_mrs(3);
    check("cke_low_ignored_state", 32'(dev_state), 32'(D_CKE_WAIT));
    check("cke_low_ignored_mr", 32'(mr_loaded), 32'h0);

    // Legal sequence
    hold_reset();
    bring_up();
    check("xpr_state", 32'(dev_state), 32'(D_XPR));
    load_mrs(1);
    check("first_mrs_mr", 32'(mr_loaded), 32'h08);
    check("first_mrs_state", 32'(dev_state), 32'(D_MRS));
    for (int i = 1; i < 7; i++) begin
      idle(3);
      issue_mrs(order[i]);
    end
    check("all_mr", 32'(mr_loaded), 32'h7F);
    idle(3);
    issue_zq(1'b1);
    check("zq_state", 32'(dev_state), 32'(D_ZQ));
    idle(15);
    check("zq_c51_ready", 32'(ready), 32'h0);
    idle(1);
    check("ready_c52", 32'(ready), 32'h1);
    check("ready_state", 32'(dev_state), 32'(D_READY));
    check("ready_err", 32'(err), 32'h0);

    // First MRS one cycle early
    hold_reset();
    bring_up();
    idle(6);
    issue_mrs(3);
    check("early_err", 32'(err), 32'h1);
    check("early_code", 32'(err_code), 32'(ERR_TIMING));
    check("early_state", 32'(dev_state), 32'(D_ERROR));
    check("early_ready", 32'(ready), 32'h0);

    // MR6 before MR3
    hold_reset();
    bring_up();
    idle(7);
    issue_mrs(6);
    check("order_code", 32'(err_code), 32'(ERR_ORDER));

    // MR index 7
    hold_reset();
    bring_up();
    idle(7);
    bus.cs_n = 1'b0; bus.act_n = 1'b1;
    bus.ras_n = 1'b0; bus.cas_n = 1'b0; bus.we_n = 1'b0;
    bus.bg = 2'b01; bus.ba = 2'b11;
    tick();
    set_nop();
    check("mr7_code", 32'(err_code), 32'(ERR_ILLEGAL));

    // Wrong index with short gap: timing reported
    hold_reset();
    bring_up();
    load_mrs(1);
    idle(2);
    issue_mrs(5);
    check("short_wrong_code", 32'(err_code), 32'(ERR_TIMING));

    // ZQ with a10=0 after MR0
    hold_reset();
    bring_up();
    load_mrs(7);
    idle(3);
    issue_zq(1'b0);
    check("zqs_code", 32'(err_code), 32'(ERR_ILLEGAL));
    check("zqs_mr", 32'(mr_loaded), 32'h7F);

    // ZQCL after MR2
    hold_reset();
    bring_up();
    load_mrs(5);
    check("five_mr", 32'(mr_loaded), 32'h7C);
    idle(3);
    issue_zq(1'b1);
    check("zq_early_code", 32'(err_code), 32'(ERR_ORDER));

    // Command during tZQinit
    hold_reset();
    bring_up();
    load_mrs(7);
    idle(3);
    issue_zq(1'b1);
    idle(2);
    issue_zq(1'b1);
    check("zq_busy_code", 32'(err_code), 32'(ERR_TIMING));

    // CKE drop in D_MRS, later timing fault must not overwrite the cause
    hold_reset();
    bring_up();
    load_mrs(1);
    bus.cke = 1'b0;
    tick();
    check("cke_code", 32'(err_code), 32'(ERR_CKE));
    bus.cke = 1'b1;
    issue_mrs(6);
    check("cke_sticky_code", 32'(err_code), 32'(ERR_CKE));
    check("cke_sticky_state", 32'(dev_state), 32'(D_ERROR));

    // RESET_n low during D_ZQ with a concurrent MRS
    hold_reset();
    bring_up();
    load_mrs(7);
    idle(3);
    issue_zq(1'b1);
    idle(4);
    bus.mem_reset_n = 1'b0;
    set_mrs(3);
    tick();
    check("memrst_state", 32'(dev_state), 32'(D_RESET));
    check("memrst_mr", 32'(mr_loaded), 32'h0);
    check("memrst_err", 32'(err), 32'h0);
    bring_up();
    load_mrs(7);
    idle(3);
    issue_zq(1'b1);
    idle(16);
    check("memrst_rerun_ready", 32'(ready), 32'h1);

    // Async nRST mid-D_MRS
    hold_reset();
    bus.mem_reset_n = 1'b1;
    bring_up();
    load_mrs(2);
    #2;
    nRST = 1'b0;
    #1;
    check("async_state", 32'(dev_state), 32'(D_RESET));
    check("async_mr", 32'(mr_loaded), 32'h0);
    nRST = 1'b1;
    bring_up();
    load_mrs(7);
    idle(3);
    issue_zq(1'b1);
    idle(16);
    check("async_rerun_ready", 32'(ready), 32'h1);
    check("async_rerun_err", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
